// File: rtl/serial_add_scheduler_pkg.sv
// Shared types and constants for the bit-serial add scheduler.
package serial_add_scheduler_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Encoding 2'd3 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef logic req_id_t;

endpackage

// File: rtl/serial_add_scheduler_fa_step.sv
// One-bit combinational full adder; the scheduler owns the carry flop.
module serial_fa_step (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_scheduler.sv
// Round-robin arbiter in front of a single bit-serial adder, with a
// valid/ready result channel that holds its outputs until consumed.
module serial_add_scheduler
  import serial_add_scheduler_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic [WIDTH-1:0] sumSh_q, sumSh_d;
  logic             carry_q, carry_d;
  req_id_t          rspId_q, rspId_d;
  req_id_t          lastGrant_q, lastGrant_d;

  req_id_t grant;
  logic    accept;
  logic    lastStep;
  logic    stepSum;
  logic    stepCarry;

  serial_fa_step uFaStep (
    .a    (aSh_q[0]),
    .b    (bSh_q[0]),
    .cin  (carry_q),
    .s    (stepSum),
    .cout (stepCarry)
  );

  // Contention alternates against the last accepted requester.
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant = ~lastGrant_q;
    end else begin
      grant = req1_valid;
    end
  end

  assign accept   = (state_q == ST_IDLE) && (req0_valid || req1_valid);
  assign lastStep = (count_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SHIFT;
      ST_SHIFT: if (lastStep) state_d = ST_DONE;
      ST_DONE:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Readies are withheld while rst is high so no handshake is reported.
  always_comb begin
    req0_ready = (state_q == ST_IDLE) && !rst && req0_valid && (grant == 1'b0);
    req1_ready = (state_q == ST_IDLE) && !rst && req1_valid && (grant == 1'b1);
    rsp_valid  = (state_q == ST_DONE);
    busy       = (state_q != ST_IDLE);
  end

  assign rsp_sum  = sumSh_q;
  assign rsp_cout = carry_q;
  assign rsp_id   = rspId_q;

  always_comb begin
    aSh_d       = aSh_q;
    bSh_d       = bSh_q;
    sumSh_d     = sumSh_q;
    carry_d     = carry_q;
    count_d     = count_q;
    rspId_d     = rspId_q;
    lastGrant_d = lastGrant_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          aSh_d       = grant ? req1_a : req0_a;
          bSh_d       = grant ? req1_b : req0_b;
          carry_d     = grant ? req1_cin : req0_cin;
          rspId_d     = grant;
          lastGrant_d = grant;
          count_d     = '0;
          sumSh_d     = '0;
        end
      end
      ST_SHIFT: begin
        carry_d = stepCarry;
        aSh_d   = aSh_q >> 1;
        bSh_d   = bSh_q >> 1;
        sumSh_d = {stepSum, sumSh_q[WIDTH-1:1]};
        count_d = count_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aSh_q       <= '0;
      bSh_q       <= '0;
      sumSh_q     <= '0;
      carry_q     <= 1'b0;
      count_q     <= '0;
      rspId_q     <= 1'b0;
      lastGrant_q <= 1'b1;
    end else begin
      aSh_q       <= aSh_d;
      bSh_q       <= bSh_d;
      sumSh_q     <= sumSh_d;
      carry_q     <= carry_d;
      count_q     <= count_d;
      rspId_q     <= rspId_d;
      lastGrant_q <= lastGrant_d;
    end
  end

endmodule

// File: doc/serial_add_scheduler.md
Name: serial_add_scheduler

Overview:
- Sequences a WIDTH-bit bit-serial add datapath and shares it between two requesters.
- Grants one request at a time using round-robin, then loads the operands.
- Runs exactly WIDTH single-bit add steps, LSB first, with the carry held in a register.
- Returns sum, carry-out and requester id on a valid/ready response channel. Sits between operand producers and any consumer of serial-add results.

Parameters:
- WIDTH, 8, operand and sum width in bits (must be >= 2).
- CW, 4, step counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk, input, 1, single system clock; all state updates on the posedge.
- rst, input, 1, synchronous active-high reset.
- req0_valid, input, 1, requester 0 has operands.
- req0_ready, output, 1, requester 0 accepted this cycle when high together with req0_valid.
- req0_a, input, WIDTH, requester 0 operand A.
- req0_b, input, WIDTH, requester 0 operand B.
- req0_cin, input, 1, requester 0 carry-in.
- req1_valid, input, 1, requester 1 has operands.
- req1_ready, output, 1, requester 1 acceptance.
- req1_a, input, WIDTH, requester 1 operand A.
- req1_b, input, WIDTH, requester 1 operand B.
- req1_cin, input, 1, requester 1 carry-in.
- rsp_valid, output, 1, result available.
- rsp_ready, input, 1, consumer takes the result.
- rsp_sum, output, WIDTH, sum bits.
- rsp_cout, output, 1, final carry-out.
- rsp_id, output, 1, requester that owns the result.
- busy, output, 1, high whenever state != IDLE.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - No negedge logic and no latches.
- Reset values:
  - State IDLE; step counter 0; last_grant = 1, so requester 0 wins first.
  - Shift registers 0; carry 0; rsp_sum 0; rsp_cout 0; rsp_id 0; rsp_valid 0; busy 0.
- States:
  - IDLE: pick grant g.
    - If exactly one req*_valid is high, g is that requester.
    - If both are high, g = ~last_grant.
    - reqg_ready = 1 combinationally; the other ready = 0.
    - On the handshake edge: A_sh <= reqg_a, B_sh <= reqg_b, carry <= reqg_cin, rsp_id <= g, last_grant <= g, count <= 0, sum_sh <= 0, go to SHIFT.
  - SHIFT: each edge, with s = A_sh[0]^B_sh[0]^carry and c = majority(A_sh[0], B_sh[0], carry):
    - carry <= c.
    - A_sh and B_sh shift right by 1.
    - sum_sh <= {s, sum_sh[WIDTH-1:1]}.
    - count <= count+1.
    - When count == WIDTH-1, go to DONE after this update.
    - Both readies are 0.
  - DONE:
    - rsp_valid = 1; rsp_sum = sum_sh; rsp_cout = carry.
    - Outputs are held stable until rsp_valid & rsp_ready.
    - On that edge go to IDLE and deassert rsp_valid.
    - Both readies are 0.
- Latency and throughput:
  - Acceptance edge E0 to rsp_valid high after edge E0+WIDTH, i.e. WIDTH cycles.
  - Minimum WIDTH+2 cycles per operation with rsp_ready tied high.
- Boundary conditions:
  - rsp_ready held low: stall in DONE indefinitely; no new request is accepted.
  - A request that drops valid before it is granted is simply not served; requesters must hold operands stable while valid and not ready.
  - rst asserted in any state: the operation is abandoned, no response is produced, and reset values apply on the next edge. A request with valid high during rst is not accepted.
  - Overflow: the result is modulo 2^WIDTH, with the overflow bit reported in rsp_cout. Carry-in is added into bit 0.
  - last_grant updates only on an acceptance, so a lone requester never loses priority bookkeeping.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2 (2'd3 illegal, recovers to IDLE);
  - default WIDTH;
  - requester id type (1 bit).
- Sub-module serial_fa_step: a combinational one-bit full adder (a, b, cin -> s, cout). It is instantiated once; the carry flop stays in the scheduler.

Test Plan:
- Basic add: reset, then req0 {a=8'hFF, b=8'h01, cin=0}, rsp_ready=1. Required: req0_ready is high in the accept cycle; rsp_valid rises exactly 8 cycles later with rsp_sum=8'h00, rsp_cout=1, rsp_id=0.
- Carry-in: req1 {a=8'h7F, b=8'h80, cin=1}. Required: rsp_sum=8'h00, rsp_cout=1, rsp_id=1; second case {8'h12, 8'h34, 0} gives rsp_sum=8'h46, rsp_cout=0.
- Arbitration: both valid continuously after reset with distinct operands. Required: grant order 0,1,0,1; each rsp_id matches the requester's operands; no requester is starved.
- Backpressure: rsp_ready=0 for 20 cycles in DONE. Required: rsp_valid, rsp_sum and rsp_id stay stable, both readies stay 0, busy=1; when rsp_ready rises, IDLE follows on the next cycle.
- Reset mid-operation: assert rst for 1 cycle at SHIFT count=3. Required: no rsp_valid pulse, busy=0 after the edge, and the next request completes correctly with req0 having priority.
